pc_sequencer: RTL

//   Next-address controller for the 16-bit program-counter register (R/L/incr_pc/Clock/Q).

---
 rtl/pc_seq_defs_pkg.sv | 15 +
 rtl/return_stack.sv | 45 ++++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pc_seq_defs_pkg.sv
// Shared state encodings and default vectors for the program-counter sequencer.
`timescale 1ps/1ps
package pc_seq_defs;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_IRQ   = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_t;

    localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
    localparam logic [15:0] DEF_IRQ_VEC   = 16'h0010;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; push and pop are never requested together.
`timescale 1ps/1ps
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] top_idx;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = IDX_W'(sp - 1'b1);
    assign dout    = mem[top_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Entries need no reset: an empty stack never exposes them.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the PC register: boot, stall, interrupt entry, ret, jump/call, increment.
//   state | meaning
//   BOOT  | load RESET_VEC, then RUN
//   RUN   | normal flow, interrupts accepted
//   IRQ   | handler active, interrupts masked until ret
//   FAULT | stack over/underflow, PC frozen until reset
`timescale 1ps/1ps
module pc_sequencer
    import pc_seq_defs::*;
#(
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(DEF_IRQ_VEC),
    parameter int              STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump_valid,
    input  logic              jump_link,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              ret_valid,
    input  logic              irq_req,
    input  logic [ADDR_W-1:0] pc_q,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_value,
    output logic              pc_incr,
    output logic              irq_ack,
    output logic              in_irq,
    output logic              fault
);
    seq_state_t        state, state_next;
    logic              push, pop, go_fault;
    logic [ADDR_W-1:0] push_data, stack_top;
    logic              stack_full, stack_empty;

    return_stack #(.DEPTH(STACK_DEPTH), .WIDTH(ADDR_W)) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_load       = 1'b0;
        pc_load_value = pc_q;
        pc_incr       = 1'b0;
        irq_ack       = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        push_data     = pc_q;
        go_fault      = 1'b0;
        state_next    = state;
        case (state)
            ST_BOOT: begin
                pc_load       = 1'b1;
                pc_load_value = RESET_VEC;
                state_next    = ST_RUN;
            end
            ST_RUN, ST_IRQ: begin
                if (stall) begin
                    state_next = state;
                end else if (state == ST_RUN && irq_req) begin
                    if (stack_full) begin
                        go_fault = 1'b1;
                    end else begin
                        push          = 1'b1;
                        pc_load       = 1'b1;
                        pc_load_value = IRQ_VEC;
                        irq_ack       = 1'b1;
                        state_next    = ST_IRQ;
                    end
                end else if (ret_valid) begin
                    if (stack_empty) begin
                        go_fault = 1'b1;
                    end else begin
                        pop           = 1'b1;
                        pc_load       = 1'b1;
                        pc_load_value = stack_top;
                        state_next    = ST_RUN;
                    end
                end else if (jump_valid) begin
                    if (jump_link && stack_full) begin
                        go_fault = 1'b1;
                    end else begin
                        push          = jump_link;
                        push_data     = pc_q + ADDR_W'(1);
                        pc_load       = 1'b1;
                        pc_load_value = jump_target;
                    end
                end else begin
                    pc_incr = 1'b1;
                end
            end
            default: state_next = ST_FAULT;
        endcase
        if (go_fault) begin
            state_next = ST_FAULT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_BOOT;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            if (go_fault) begin
                fault <= 1'b1;
            end
        end
    end

    assign in_irq = (state == ST_IRQ);

endmodule
